sonar_tof_capture: RTL and testbench

SONAR_TOF_CAPTURE -- requirements
Module: sonar_tof_capture

---
 rtl/sonar_tof_capture_if.sv | 21 ++
 rtl/sonar_tof_capture.sv | 236 +++++++++++++++++++++++
 tb/tb_sonar_tof_capture.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sonar_tof_capture_if.sv
// Register bus between a host and the sonar time-of-flight capture block.
// Latency: single-cycle registered acknowledge; every request is answered on the next clk.
// Backpressure: none; the slave accepts every valid cycle.
interface sonar_tof_capture_if;
    logic        wb_valid_i;
    logic [3:0]  wbs_adr_i;
    logic        wbs_strb_i;
    logic [15:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [15:0] wbs_dat_o;

    modport master (
        output wb_valid_i, wbs_adr_i, wbs_strb_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wb_valid_i, wbs_adr_i, wbs_strb_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/sonar_tof_capture.sv
// Multi-channel sonar echo detector: blanking, threshold+hold detection, per-channel TOF capture.
// Latency: detection and state updates land on the clk edge of the ce_pcm tick; bus ack/data one clk after request.
// Backpressure: none; every bus request is acknowledged and every ce_pcm tick is consumed.
module sonar_tof_capture #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 16,
    parameter int TIMER_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce_pcm,
    input  logic                         mclear,
    input  logic [CHANNELS*DATA_W-1:0]   env_i,
    sonar_tof_capture_if.slave           bus,
    output logic [CHANNELS-1:0]          det_o,
    output logic                         irq_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BLANK  = 2'd1;
    localparam logic [1:0] S_LISTEN = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Compare width wide enough for both envelope samples and the 16-bit threshold.
    localparam int CMP_W = (DATA_W > 16) ? DATA_W : 16;

    logic [1:0]          state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [TIMER_W-1:0]  tof_q [CHANNELS];
    logic [TIMER_W-1:0]  tof_d [CHANNELS];
    logic [15:0]         run_q [CHANNELS];
    logic [15:0]         run_d [CHANNELS];
    logic [CHANNELS-1:0] det_q, det_d;
    logic [CHANNELS-1:0] ch_en_q, ch_en_d;
    logic                timeout_q, timeout_d;
    logic                irq_pend_q, irq_pend_d;
    logic                irq_en_q, irq_en_d;
    logic [15:0]         thr_q, thr_d;
    logic [15:0]         blank_q, blank_d;
    logic [15:0]         window_q, window_d;
    logic [15:0]         hold_q, hold_d;
    logic                ack_q, ack_d;
    logic [15:0]         rdat_q, rdat_d;

    logic                wr_en;
    logic                wr_ctrl;
    logic                do_start;
    logic                do_abort;
    logic [15:0]         rd_mux;

    // Read mux: returns the pre-edge value of the addressed register; unmapped addresses read 0.
    always_comb begin
        rd_mux = 16'd0;
        case (bus.wbs_adr_i)
            4'd0: rd_mux = {14'd0, irq_en_q, 1'b0};
            4'd1: rd_mux = {8'(det_q), 4'd0, irq_pend_q, timeout_q, state_q};
            4'd2: rd_mux = thr_q;
            4'd3: rd_mux = blank_q;
            4'd4: rd_mux = window_q;
            4'd5: rd_mux = hold_q;
            4'd6: rd_mux = 16'(ch_en_q);
            4'd7: rd_mux = 16'(timer_q);
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (bus.wbs_adr_i == 4'(8 + i)) begin
                        rd_mux = 16'(tof_q[i]);
                    end
                end
            end
        endcase
    end

    // Next-state logic: bus writes, capture FSM, per-channel detection, interrupt pending.
    always_comb begin
        logic [TIMER_W-1:0] timer_inc;
        logic [15:0]        hold_eff;
        logic [15:0]        hold_m1;
        logic [16:0]        run_inc;
        logic               all_det;
        logic               expired;
        logic               done_entry;

        state_d    = state_q;
        timer_d    = timer_q;
        det_d      = det_q;
        ch_en_d    = ch_en_q;
        timeout_d  = timeout_q;
        irq_pend_d = irq_pend_q;
        irq_en_d   = irq_en_q;
        thr_d      = thr_q;
        blank_d    = blank_q;
        window_d   = window_q;
        hold_d     = hold_q;
        for (int i = 0; i < CHANNELS; i++) begin
            tof_d[i] = tof_q[i];
            run_d[i] = run_q[i];
        end
        done_entry = 1'b0;
        all_det    = 1'b0;
        expired    = 1'b0;
        run_inc    = 17'd0;

        // Bus response is registered for every request cycle.
        ack_d  = bus.wb_valid_i;
        rdat_d = bus.wb_valid_i ? rd_mux : 16'd0;

        wr_en    = bus.wb_valid_i & bus.wbs_strb_i;
        wr_ctrl  = wr_en && (bus.wbs_adr_i == 4'd0);
        do_start = wr_ctrl & bus.wbs_dat_i[0];
        do_abort = (wr_ctrl & bus.wbs_dat_i[2]) | mclear;

        if (wr_ctrl) irq_en_d = bus.wbs_dat_i[1];
        if (wr_en) begin
            case (bus.wbs_adr_i)
                4'd2: thr_d    = bus.wbs_dat_i;
                4'd3: blank_d  = bus.wbs_dat_i;
                4'd4: window_d = bus.wbs_dat_i;
                4'd5: hold_d   = bus.wbs_dat_i;
                4'd6: ch_en_d  = bus.wbs_dat_i[CHANNELS-1:0];
                default: ;
            endcase
        end

        // Timer saturates rather than wrapping so a long listen never aliases to a short TOF.
        timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        hold_eff  = (hold_q == 16'd0) ? 16'd1 : hold_q;
        hold_m1   = hold_eff - 16'd1;

        case (state_q)
            S_BLANK: begin
                if (ce_pcm) begin
                    timer_d = timer_inc;
                    if (({1'b0, 16'(timer_q)} + 17'd1) >= {1'b0, blank_q}) begin
                        state_d = S_LISTEN;
                    end
                end
            end
            S_LISTEN: begin
                if (ce_pcm) begin
                    timer_d = timer_inc;
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (ch_en_q[i] && !det_q[i]) begin
                            if (CMP_W'(env_i[i*DATA_W +: DATA_W]) >= CMP_W'(thr_q)) begin
                                run_inc  = {1'b0, run_q[i]} + 17'd1;
                                run_d[i] = run_inc[15:0];
                                if (run_inc >= {1'b0, hold_eff}) begin
                                    det_d[i] = 1'b1;
                                    // Report the first tick of the qualifying run.
                                    tof_d[i] = TIMER_W'({1'b0, 16'(timer_q)} - {1'b0, hold_m1});
                                end
                            end else begin
                                run_d[i] = 16'd0;
                            end
                        end
                    end
                    // Detections on this tick count before judging completion or expiry.
                    all_det = ((det_d & ch_en_q) == ch_en_q);
                    expired = (16'(timer_inc) >= window_q);
                    if (all_det || expired) begin
                        state_d    = S_DONE;
                        timeout_d  = ~all_det;
                        done_entry = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Completion beats a coincident software clear so an interrupt is never lost.
        if (done_entry) begin
            irq_pend_d = 1'b1;
        end else if (wr_en && (bus.wbs_adr_i == 4'd1) && bus.wbs_dat_i[3]) begin
            irq_pend_d = 1'b0;
        end

        // Abort/master clear outrank start; both wipe results.
        if (do_abort || do_start) begin
            state_d    = do_abort ? S_IDLE : S_BLANK;
            timer_d    = '0;
            det_d      = '0;
            timeout_d  = 1'b0;
            irq_pend_d = 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                tof_d[i] = '0;
                run_d[i] = 16'd0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            det_q      <= '0;
            ch_en_q    <= '1;
            timeout_q  <= 1'b0;
            irq_pend_q <= 1'b0;
            irq_en_q   <= 1'b0;
            thr_q      <= 16'h00F0;
            blank_q    <= 16'd0;
            window_q   <= 16'hFFFF;
            hold_q     <= 16'd1;
            ack_q      <= 1'b0;
            rdat_q     <= 16'd0;
            for (int i = 0; i < CHANNELS; i++) begin
                tof_q[i] <= '0;
                run_q[i] <= 16'd0;
            end
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            det_q      <= det_d;
            ch_en_q    <= ch_en_d;
            timeout_q  <= timeout_d;
            irq_pend_q <= irq_pend_d;
            irq_en_q   <= irq_en_d;
            thr_q      <= thr_d;
            blank_q    <= blank_d;
            window_q   <= window_d;
            hold_q     <= hold_d;
            ack_q      <= ack_d;
            rdat_q     <= rdat_d;
            for (int i = 0; i < CHANNELS; i++) begin
                tof_q[i] <= tof_d[i];
                run_q[i] <= run_d[i];
            end
        end
    end

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = rdat_q;
    assign det_o         = det_q;
    assign irq_o         = irq_pend_q & irq_en_q;

endmodule

// File: tb/tb_sonar_tof_capture.sv
// Directed bench for sonar_tof_capture (4 channels, 16-bit data and timer).
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 time unit after the next posedge.
// Backpressure: not applicable; the DUT acknowledges every request.
module tb_sonar_tof_capture;

    logic        clk;
    logic        rst;
    logic        ce_pcm;
    logic        mclear;
    logic [63:0] env;
    logic [3:0]  det_o;
    logic        irq_o;

    int n_cmp = 0;
    int n_err = 0;

    sonar_tof_capture_if bus_if ();

    sonar_tof_capture #(
        .CHANNELS (4),
        .DATA_W   (16),
        .TIMER_W  (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce_pcm (ce_pcm),
        .mclear (mclear),
        .env_i  (env),
        .bus    (bus_if),
        .det_o  (det_o),
        .irq_o  (irq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus_if.wb_valid_i = 1'b1;
        bus_if.wbs_strb_i = 1'b1;
        bus_if.wbs_adr_i  = a;
        bus_if.wbs_dat_i  = d;
        @(posedge clk); #1;
        bus_if.wb_valid_i = 1'b0;
        bus_if.wbs_strb_i = 1'b0;
    endtask

    // Read and check both the acknowledge and the returned data.
    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
        bus_if.wb_valid_i = 1'b1;
        bus_if.wbs_strb_i = 1'b0;
        bus_if.wbs_adr_i  = a;
        @(posedge clk); #1;
        bus_if.wb_valid_i = 1'b0;
        chk(tag, {15'd0, bus_if.wbs_ack_o, bus_if.wbs_dat_o}, {15'd0, 1'b1, exp});
    endtask

    task automatic ticks(input int n);
        ce_pcm = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        ce_pcm = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        ce_pcm = 1'b0;
        mclear = 1'b0;
        env    = 64'd0;
        bus_if.wb_valid_i = 1'b0;
        bus_if.wbs_strb_i = 1'b0;
        bus_if.wbs_adr_i  = 4'd0;
        bus_if.wbs_dat_i  = 16'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_ack", {31'd0, bus_if.wbs_ack_o}, 32'd0);
        chk("rst_det", {28'd0, det_o}, 32'd0);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        rd_chk("rst_status", 4'd1, 16'h0000);
        rd_chk("rst_thr",    4'd2, 16'h00F0);
        rd_chk("rst_blank",  4'd3, 16'h0000);
        rd_chk("rst_window", 4'd4, 16'hFFFF);
        rd_chk("rst_hold",   4'd5, 16'h0001);
        rd_chk("rst_chen",   4'd6, 16'h000F);
        rd_chk("rst_timer",  4'd7, 16'h0000);

        // Basic detection: BLANK=10, HOLD=1, ch0 crosses on tick 25
        wr(4'd6, 16'h0001);
        wr(4'd3, 16'd10);
        wr(4'd0, 16'h0003);
        ticks(25);
        rd_chk("a_status_listen", 4'd1, 16'h0002);
        rd_chk("a_timer25",       4'd7, 16'd25);
        env = 64'h0000_0000_0000_0100;
        ticks(1);
        env = 64'd0;
        chk("a_det", {28'd0, det_o}, 32'h1);
        chk("a_irq", {31'd0, irq_o}, 32'h1);
        rd_chk("a_status_done", 4'd1, 16'h010B);
        rd_chk("a_tof0",        4'd8, 16'd25);
        ticks(3);
        rd_chk("a_timer_hold",  4'd7, 16'd26);
        rd_chk("a_unmapped_tof", 4'd12, 16'h0000);
        rd_chk("a_ctrl",        4'd0, 16'h0002);

        // HOLD=3 run qualification on ch1
        wr(4'd5, 16'd3);
        wr(4'd3, 16'd0);
        wr(4'd6, 16'h0002);
        wr(4'd0, 16'h0003);
        chk("b_irq_cleared", {31'd0, irq_o}, 32'h0);
        chk("b_det_cleared", {28'd0, det_o}, 32'h0);
        ticks(40);
        env = 64'h0000_0000_0100_0000;
        ticks(2);
        env = 64'd0;
        ticks(8);
        env = 64'h0000_0000_0100_0000;
        ticks(2);
        chk("b_det_pending", {28'd0, det_o}, 32'h0);
        ticks(1);
        env = 64'd0;
        chk("b_det", {28'd0, det_o}, 32'h2);
        rd_chk("b_tof1",   4'd9, 16'd50);
        rd_chk("b_status", 4'd1, 16'h020B);

        // Window expiry on ch2 with no crossing
        wr(4'd4, 16'd100);
        wr(4'd6, 16'h0004);
        wr(4'd5, 16'd1);
        wr(4'd0, 16'h0003);
        ticks(99);
        rd_chk("c_status_listen", 4'd1, 16'h0002);
        ticks(1);
        rd_chk("c_status_timeout", 4'd1, 16'h000F);
        rd_chk("c_timer", 4'd7, 16'd100);
        chk("c_irq", {31'd0, irq_o}, 32'h1);
        wr(4'd1, 16'h0008);
        chk("c_irq_w1c", {31'd0, irq_o}, 32'h0);
        rd_chk("c_status_w1c", 4'd1, 16'h0007);

        // Envelope above threshold only during blanking
        wr(4'd4, 16'hFFFF);
        wr(4'd3, 16'd20);
        wr(4'd6, 16'h0001);
        env = 64'h0000_0000_0000_0100;
        wr(4'd0, 16'h0003);
        ticks(19);
        rd_chk("d_status_blank", 4'd1, 16'h0001);
        rd_chk("d_timer19", 4'd7, 16'd19);
        ticks(1);
        env = 64'd0;
        ticks(5);
        rd_chk("d_status_listen", 4'd1, 16'h0002);
        rd_chk("d_timer25", 4'd7, 16'd25);
        chk("d_det", {28'd0, det_o}, 32'h0);

        // Start and abort in one write during LISTEN
        wr(4'd6, 16'h0003);
        env = 64'h0000_0000_0000_0100;
        ticks(1);
        env = 64'd0;
        chk("e_det_partial", {28'd0, det_o}, 32'h1);
        rd_chk("e_status_partial", 4'd1, 16'h0102);
        wr(4'd0, 16'h0005);
        rd_chk("e_status", 4'd1, 16'h0000);
        rd_chk("e_timer",  4'd7, 16'h0000);
        rd_chk("e_tof0",   4'd8, 16'h0000);
        chk("e_det", {28'd0, det_o}, 32'h0);

        // W1C coincident with DONE entry (empty CH_EN completes on first LISTEN tick)
        wr(4'd6, 16'h0000);
        wr(4'd3, 16'd0);
        wr(4'd0, 16'h0003);
        ticks(1);
        rd_chk("f_status_listen", 4'd1, 16'h0002);
        bus_if.wb_valid_i = 1'b1;
        bus_if.wbs_strb_i = 1'b1;
        bus_if.wbs_adr_i  = 4'd1;
        bus_if.wbs_dat_i  = 16'h0008;
        ce_pcm = 1'b1;
        @(posedge clk); #1;
        bus_if.wb_valid_i = 1'b0;
        bus_if.wbs_strb_i = 1'b0;
        ce_pcm = 1'b0;
        rd_chk("f_status_done", 4'd1, 16'h000B);
        chk("f_irq", {31'd0, irq_o}, 32'h1);

        // Master clear
        mclear = 1'b1;
        @(posedge clk); #1;
        mclear = 1'b0;
        rd_chk("g_status_mclear", 4'd1, 16'h0000);
        chk("g_irq", {31'd0, irq_o}, 32'h0);

        // Reset mid-capture
        wr(4'd6, 16'h000F);
        wr(4'd2, 16'h0200);
        wr(4'd0, 16'h0003);
        ticks(5);
        rd_chk("h_timer_pre", 4'd7, 16'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("h_ack", {31'd0, bus_if.wbs_ack_o}, 32'h0);
        chk("h_irq", {31'd0, irq_o}, 32'h0);
        rd_chk("h_status", 4'd1, 16'h0000);
        rd_chk("h_timer",  4'd7, 16'h0000);
        rd_chk("h_thr",    4'd2, 16'h00F0);
        rd_chk("h_ctrl",   4'd0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
